display_scan_controller: RTL and testbench
==========================================

Name: display_scan_controller

Overview:
- Time-multiplexes one `segment_display` decoder (4-bit `count` in, 7-bit `display` out) across a 4-digit common-anode seven-segment panel.
- Holds a frame-coherent shadow copy of four BCD digits and steps through them at a fixed refresh rate.
- Drives the decoder's `count` input and the panel's digit anodes.
- Inserts a ghosting guard interval at each digit switch, and applies per-digit blanking and blinking.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot; must be ≥ GUARD+2.
- GUARD, 2: cycles at the start of each slot during which all anodes are held off; must be ≥ 1.
- BLINK_DIV, 250: number of digit-slot ticks per blink phase toggle; must be ≥ 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- digits  in  16  four BCD digits; [3:0] = digit 0 (rightmost), [15:12] = digit 3
- blank  in  4  per-digit force-off mask; 1 = digit never lit
- blink_en  in  4  per-digit blink mask; 1 = digit off during blink phase 1
- count  out  4  registered digit value, connected to segment_display.count
- seg_in  in  7  segment_display.display, returned to this block
- seg  out  7  panel segments, active-low
- anode  out  4  registered digit enables, active-low, at most one low at a time
- frame  out  1  one-cycle pulse when digit 0's slot begins

Behaviour:
- Reset (asynchronous, rst_n=0):
  - refresh_cnt=0, guard_cnt=0, idx=0, blink_cnt=0, blink_phase=0, shadow=16'h0000.
  - Outputs: count=4'h0, anode=4'b1111, frame=0.
  - Reset counts as the start of digit 0's slot, including its guard interval.
- Refresh counter:
  - refresh_cnt increments every cycle.
  - When refresh_cnt==REFRESH_DIV-1, tick=1 and refresh_cnt returns to 0 on the next edge.
- On the edge where tick=1:
  - idx <= idx+1 mod 4.
  - anode <= 4'b1111 and guard_cnt <= 0.
  - count <= the new slot's digit (see next item).
- Frame boundary (tick while idx==3):
  - shadow <= digits and count <= digits[3:0] on the same edge, so no stale value is shown.
  - frame=1 for exactly that following cycle.
- Shadow loading:
  - On all other ticks, count <= shadow[4*(idx+1)+3 -: 4].
  - digits changes between frame boundaries are never visible mid-frame.
- Guard interval:
  - guard_cnt counts up from 0 while anodes are off.
  - On the edge where guard_cnt reaches GUARD-1, the digit's anode is asserted low, unless that digit is suppressed (see next item).
  - The anode then stays low until the next tick.
- Suppression:
  - A digit is suppressed when blank[idx]=1, or when blink_en[idx]=1 and blink_phase=1.
  - Suppression is evaluated every cycle after the guard interval.
  - A mask change mid-slot takes effect on the next edge.
- Blink:
  - blink_cnt counts ticks.
  - At blink_cnt==BLINK_DIV-1 with tick, blink_cnt <= 0 and blink_phase toggles.
- Segment gating:
  - seg is combinational: seg = (anode==4'b1111) ? 7'h7F : seg_in.
- count values ≥ 10 are passed through unmodified; decoding them is the decoder's concern.
- Reset mid-slot: all outputs return to reset values immediately, with no glitching anode (anode is registered).

Test Plan:
Parameters for all scenarios: REFRESH_DIV=8, GUARD=2, BLINK_DIV=4.
- Reset release, digits=16'h4321, masks 0:
  - anode=1111 for 2 cycles, then 1110 with count=0 until the first tick.
  - At the first frame, count=1 and anode goes to 1110 again after the guard.
  - Slots that follow: count=2 with 1101, count=3 with 1011, count=4 with 0111; each slot lasts 8 cycles, 2 of them guard.
- Mid-frame coherence: change digits to 16'h9876 while idx=1.
  - Slots 2 and 3 still show 3 and 4.
  - frame pulses, then slot 0 shows count=6.
- blank=4'b0100:
  - During slot 2, anode=1111 and seg=7'h7F for all 8 cycles.
  - The other digits are unaffected.
- blink_en=4'b0001:
  - Digit 0 is dark in alternate blink phases; the phase toggles every 4 ticks.
  - Digit 0's anode is low only while blink_phase=0.
- Reset asserted in the middle of slot 2's lit interval:
  - anode=1111, count=0 and frame=0 in the same cycle.
  - After release, the sequence restarts from the first scenario's timing.
- One-hot check: across 200 cycles with random digits and masks, anode never has more than one 0.

Source files
------------

// File: rtl/display_scan_controller.sv
// Scans four BCD digits onto a common-anode seven-segment panel through one shared decoder,
// with a frame-coherent shadow copy, an all-off guard at each digit switch, and blank/blink masks.
module display_scan_controller #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2,
    parameter int BLINK_DIV   = 250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits,
    input  logic [3:0]  blank,
    input  logic [3:0]  blink_en,
    output logic [3:0]  count,
    input  logic [6:0]  seg_in,
    output logic [6:0]  seg,
    output logic [3:0]  anode,
    output logic        frame
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int GW = $clog2(GUARD + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);

    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD - 1);
    localparam logic [GW-1:0] GUARD_END  = GW'(GUARD);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [RW-1:0] refresh_cnt;
    logic [GW-1:0] guard_cnt;
    logic [1:0]    idx;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [15:0]   shadow;

    logic          tick;
    logic          wrap;
    logic          in_lit;
    logic          suppressed;
    logic [1:0]    idx_nxt;
    logic [3:0]    lit_anode;

    always_comb begin
        tick       = (refresh_cnt == REF_LAST);
        wrap       = tick && (idx == 2'd3);
        idx_nxt    = idx + 2'd1;
        // guard_cnt saturates at GUARD, so this stays true for the rest of the slot
        in_lit     = (guard_cnt >= GUARD_LAST);
        suppressed = blank[idx] | (blink_en[idx] & blink_phase);
        lit_anode  = ~(4'b0001 << idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            guard_cnt   <= '0;
            idx         <= 2'd0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            shadow      <= 16'h0000;
            count       <= 4'h0;
            anode       <= 4'b1111;
            frame       <= 1'b0;
        end else begin
            refresh_cnt <= tick ? '0 : refresh_cnt + RW'(1);
            frame       <= wrap;
            if (tick) begin
                idx       <= idx_nxt;
                guard_cnt <= '0;
                anode     <= 4'b1111;
                // On the frame boundary the fresh digit bypasses the shadow so slot 0 is never stale
                if (wrap) begin
                    shadow <= digits;
                    count  <= digits[3:0];
                end else begin
                    count  <= shadow[{idx_nxt, 2'b00} +: 4];
                end
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt   <= blink_cnt + BW'(1);
                end
            end else begin
                if (guard_cnt != GUARD_END)
                    guard_cnt <= guard_cnt + GW'(1);
                if (in_lit)
                    anode <= suppressed ? 4'b1111 : lit_anode;
            end
        end
    end

    assign seg = (anode == 4'b1111) ? 7'h7F : seg_in;

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomized bench for display_scan_controller; expectations come from a slot/time model
// derived from elapsed cycles since reset.
module tb_display_scan_controller;
    localparam int R = 8;
    localparam int G = 2;
    localparam int B = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits = 16'h4321;
    logic [3:0]  blank = 4'h0;
    logic [3:0]  blink_en = 4'h0;
    logic [6:0]  seg_in = 7'h00;
    logic [3:0]  count;
    logic [6:0]  seg;
    logic [3:0]  anode;
    logic        frame;

    int          t = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] mshadow = 16'h0000;
    logic [3:0]  mblank = 4'h0;
    logic [3:0]  mblink = 4'h0;

    display_scan_controller #(.REFRESH_DIV(R), .GUARD(G), .BLINK_DIV(B)) dut (
        .clk(clk), .rst_n(rst_n), .digits(digits), .blank(blank), .blink_en(blink_en),
        .count(count), .seg_in(seg_in), .seg(seg), .anode(anode), .frame(frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    // Expected outputs as a function of cycles since reset: slot = t/R, position in slot = t%R
    task automatic check_outputs();
        int   slot;
        int   pos;
        int   di;
        logic phase;
        logic supp;
        logic [3:0] ea;
        slot  = t / R;
        pos   = t % R;
        di    = slot % 4;
        phase = ((slot / B) % 2) == 1;
        supp  = mblank[di] | (mblink[di] & phase);
        ea    = (pos < G || supp) ? 4'b1111 : ~(4'b0001 << di);
        chk("count", 16'(count), 16'(mshadow[4*di +: 4]));
        chk("anode", 16'(anode), 16'(ea));
        chk("frame", 16'(frame), 16'(pos == 0 && di == 0 && slot > 0));
        chk("seg", 16'(seg), 16'((ea == 4'b1111) ? 7'h7F : seg_in));
        chk("onehot", 16'($countones(~anode) <= 1), 16'd1);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) begin
            if (t % R == R - 1 && (t / R) % 4 == 3)
                mshadow = digits;
            mblank = blank;
            mblink = blink_en;
            t++;
        end else begin
            t = 0;
            mshadow = 16'h0000;
        end
        @(negedge clk);
        check_outputs();
        seg_in = 7'($urandom);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        bit found;
        // Power-on reset
        run(3);
        rst_n = 1'b1;
        // Two frames of 4321; switch digits while slot idx=1 of the second frame
        run(42);
        digits = 16'h9876;
        run(54);
        // Blank digit 2
        blank = 4'b0100;
        run(64);
        blank = 4'b0000;
        // Blink digit 0 across several phase toggles
        blink_en = 4'b0001;
        run(160);
        blink_en = 4'b0000;
        // Asynchronous reset in the middle of slot 2's lit interval
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (t % (4 * R) == 2 * R + 4) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        chk("reset_align", 16'(found), 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_anode", 16'(anode), 16'hF);
        chk("rst_count", 16'(count), 16'h0);
        chk("rst_frame", 16'(frame), 16'h0);
        t = 0;
        mshadow = 16'h0000;
        run(2);
        rst_n = 1'b1;
        digits = 16'h4321;
        run(64);
        // Random digits and masks
        for (int i = 0; i < 200; i++) begin
            digits = 16'($urandom);
            if ($urandom_range(0, 7) == 0) blank = 4'($urandom);
            if ($urandom_range(0, 7) == 0) blink_en = 4'($urandom);
            cycle();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
